// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory for the MIPS MEM stage: request/response handshake,
// configurable wait states, big-endian byte/halfword/word access with error reporting.
module data_memory_ctrl #(
   parameter int ADDR_W      = 9,
   parameter int DEPTH       = 512,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [1:0]        size,
   input  logic              rw,
   input  logic              se,
   output logic              rsp_valid,
   output logic [31:0]       rdata,
   output logic              err
);

   localparam int         IDX_W    = $clog2(DEPTH);
   localparam int         AW1      = ADDR_W + 1;
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t           state;
   logic [3:0]       cnt;
   logic [7:0]       mem [0:DEPTH-1];

   logic             accept;
   logic [2:0]       nbytes;
   logic             align_err;
   logic             range_err;
   logic             acc_err;
   logic [AW1-1:0]   last_addr;
   logic [IDX_W-1:0] base;
   logic [31:0]      word_rd;
   logic [31:0]      rd_ext;
   logic [31:0]      rsp_data;
   logic [31:0]      res_data_p0;
   logic             res_err_p0;

   // Select the addressed byte/halfword out of the big-endian word and extend it.
   function automatic logic [31:0] extend_rd(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] lane, input logic sx);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = w[8*(3 - int'(lane)) +: 8];
      h = lane[1] ? w[15:0] : w[31:16];
      case (sz)
         2'b00:   extend_rd = sx ? 32'(b) : {24'd0, b};
         2'b01:   extend_rd = sx ? 32'(h) : {16'd0, h};
         default: extend_rd = w;
      endcase
   endfunction

   always_comb begin
      nbytes    = 3'd4;
      align_err = 1'b0;
      case (size)
         2'b00:   nbytes = 3'd1;
         2'b01: begin
            nbytes    = 3'd2;
            align_err = addr[0];
         end
         2'b10:   align_err = |addr[1:0];
         default: align_err = 1'b1;
      endcase
   end

   assign last_addr = {1'b0, addr} + AW1'(nbytes - 3'd1);
   assign range_err = last_addr >= AW1'(DEPTH);
   assign acc_err   = align_err | range_err;
   assign accept    = req_valid & req_ready;

   // Aligned accesses never cross a word, so all reads come from one word-aligned group.
   assign base     = addr[IDX_W-1:0] & ~IDX_W'(3);
   assign word_rd  = {mem[base], mem[base | IDX_W'(1)], mem[base | IDX_W'(2)], mem[base | IDX_W'(3)]};
   assign rd_ext   = extend_rd(word_rd, size, addr[1:0], se);
   assign rsp_data = (acc_err | rw) ? 32'd0 : rd_ext;

   always_ff @(posedge clk) begin
      if (accept && !reset && rw && !acc_err) begin
         case (size)
            2'b00: mem[base | IDX_W'(addr[1:0])] <= wdata[7:0];
            2'b01: begin
               mem[base | IDX_W'({addr[1], 1'b0})] <= wdata[15:8];
               mem[base | IDX_W'({addr[1], 1'b1})] <= wdata[7:0];
            end
            default: begin
               mem[base]              <= wdata[31:24];
               mem[base | IDX_W'(1)]  <= wdata[23:16];
               mem[base | IDX_W'(2)]  <= wdata[15:8];
               mem[base | IDX_W'(3)]  <= wdata[7:0];
            end
         endcase
      end
   end

   // p0: result captured at accept, held through the wait states
   always_ff @(posedge clk) begin
      if (accept) begin
         res_data_p0 <= rsp_data;
         res_err_p0  <= acc_err;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rdata     <= 32'd0;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (WAIT_STATES > 0) begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end else begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                     rdata     <= rsp_data;
                     err       <= acc_err;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rdata     <= res_data_p0;
                  err       <= res_err_p0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rdata     <= 32'd0;
               err       <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rdata     <= 32'd0;
               err       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Clocked, parametrised byte-addressed data memory for the MIPS pipeline's MEM stage. It replaces the combinational data memory with a request/response handshake, configurable wait states, big-endian byte/halfword/word access with optional sign extension, and alignment/range error reporting. The pipeline control stalls on `req_ready`/`rsp_valid`.

## Interface
- `ADDR_W`, default 9: byte-address width.
- `DEPTH`, default 512: number of byte locations; must satisfy DEPTH ≤ 2^ADDR_W and DEPTH a multiple of 4.
- `WAIT_STATES`, default 1: extra cycles between accept and response, range 0–15.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept; high only in IDLE.
- `addr` input ADDR_W: byte address.
- `wdata` input 32: write data, right-justified.
- `size` input 2: access size; 00 byte, 01 halfword, 10 word, 11 illegal.
- `rw` input 1: 0 read, 1 write.
- `se` input 1: sign-extend byte/halfword reads.
- `rsp_valid` output 1: one-cycle response pulse.
- `rdata` output 32: read result; 0 whenever `rsp_valid`=0.
- `err` output 1: request rejected; qualified by `rsp_valid`.

## Operation
- Storage is a byte array [0:DEPTH-1], big-endian: the byte at `addr` is most significant.
- The byte array is not cleared by reset.
- Accept occurs on the edge where `req_valid`&&`req_ready`.
- At accept, `addr`, `wdata`, `size`, `rw` and `se` are latched. Inputs are don't-care afterwards.
- Error conditions, evaluated at accept:
  - size=11;
  - halfword with addr[0]≠0;
  - word with addr[1:0]≠0;
  - addr+bytes−1 ≥ DEPTH.
- On error: no memory change, `err`=1 in the response, `rdata`=0.
- Write commits at the accepting edge:
  - byte: mem[A]=wdata[7:0];
  - halfword: mem[A]=wdata[15:8], mem[A+1]=wdata[7:0];
  - word: mem[A..A+3]=wdata[31:24..7:0].
- Read data is sampled at the accepting edge into a result register.
  - byte: upper 24 bits = se ? mem[A][7] : 0.
  - halfword: upper 16 bits = se ? mem[A][7] : 0.
  - word: `se` ignored.
- A write response carries `rdata`=0 and `err`=0.
- FSM:
  - IDLE: `req_ready`=1. On accept → WAIT with counter=WAIT_STATES−1 if WAIT_STATES>0, else → RESP.
  - WAIT: counter decrements each edge; at counter=0 → RESP.
  - RESP: `rsp_valid`=1. Unconditionally → IDLE on the next edge. No response backpressure.
- Reset mid-operation: FSM → IDLE and the pending response is dropped. A write already committed at accept remains in memory.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rdata`=0, `err`=0. The counter is cleared.
- Accept at edge E0 → `rsp_valid` is high for exactly the cycle following edge E0+WAIT_STATES.
- With WAIT_STATES=0 the response appears in the cycle right after the accept.
- `req_ready` is low from E0 until the edge that leaves RESP.
- Back-to-back accepts are spaced WAIT_STATES+2 cycles apart.
- A read accepted in the cycle after a write's response observes that write.
- `rdata`/`err` are registered outputs, stable throughout the `rsp_valid` cycle and 0 otherwise.
- `req_valid` while `req_ready`=0 is ignored. The requester must hold the request until accepted.

## Test plan
- Write word 0x12345678 at addr 8, then read word at 8 → rdata=0x12345678. Byte read at 8 → 0x00000012. Halfword read at 10 → 0x00005678.
- Write byte 0xF0 at addr 3; read byte at 3 with se=1 → 0xFFFFFFF0, with se=0 → 0x000000F0. Write halfword 0x8001 at 4; read with se=1 → 0xFFFF8001.
- Word at addr 6, halfword at addr 1, size=11, and a word at DEPTH−2 → each gets err=1 and rdata=0. A follow-up read confirms memory is unchanged.
- WAIT_STATES=0 and WAIT_STATES=3 builds: `req_valid` held high continuously → `rsp_valid` at cycle 1 and 4 after accept; accepts spaced 2 and 5 cycles apart; `req_ready`=0 throughout.
- Assert `reset` during WAIT after a write of 0xAABBCCDD at 0 → outputs return to reset values at once and no `rsp_valid` is issued. After release, reading addr 0 → 0xAABBCCDD.
